led_ctrl: RTL

LED_CTRL -- requirements
Module: led_ctrl

---
 rtl/led_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/led_ctrl.sv
// led_ctrl: bus-programmable 8-LED controller with blink modes and an error display.
//
// Optional feature macro: LED_CTRL_HEARTBEAT_EN
//   defined   -> in NORMAL, leds[7] shows the slow blink regardless of MODE[15:14]
//   undefined -> leds[7] follows MODE[15:14] like every other LED
//
// Parameters:
//   TICK_DIV  clocks per blink tick (2 .. 2^24)
// Ports:
//   clk       system clock, all state on rising edge
//   rst_n     asynchronous active-low reset
//   stb       one-cycle bus strobe
//   we        1 = write, 0 = read (qualified by stb)
//   addr      register select: 0 = MODE, 1 = CTRL
//   data_in   write data
//   data_out  combinational read data, zero unless reading
//   ack       access acknowledge (equal to stb)
//   err_req   hardware error request, level, active-high
//   err_code  error pattern, sampled with err_req
//   leds      registered LED drive
module led_ctrl #(
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  input  logic        err_req,
  input  logic [7:0]  err_code,
  output logic [7:0]  leds
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [0:0] {StNormal, StError} state_e;

  state_e          state_q, state_d;
  logic [15:0]     mode_q, mode_d;
  logic [7:0]      code_q, code_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      phase_q, phase_d;
  logic [7:0]      leds_q, leds_d;
  logic [1:0]      sync_q;
  logic            run;
  logic            tick;
  logic            fast, slow;
  logic            wr_mode, wr_clear;
  logic            err_active;
  logic            unused_data;

  assign unused_data = ^data_in[31:16];

  // Reset release is re-timed through two flops; counters hold until it arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end
  assign run = sync_q[1];

  // Free-running tick and phase counters, independent of bus and FSM.
  assign tick = run && (cnt_q == CntW'(TICK_DIV - 1));

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (run) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) phase_d = phase_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 3'd0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign fast = phase_q[0];
  assign slow = phase_q[2];

  // Bus decode.
  assign ack      = stb;
  assign wr_mode  = stb && we && !addr;
  assign wr_clear = stb && we && addr && data_in[0];

  always_comb begin
    mode_d = mode_q;
    if (wr_mode) mode_d = data_in[15:0];
  end

  always_comb begin
    data_out = 32'h0;
    if (stb && !we) begin
      data_out = addr ? {15'b0, err_active, 8'b0, code_q} : {16'b0, mode_q};
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StNormal;
    else        state_q <= state_d;
  end

  // FSM: next state and error-code latch. In ERROR a fresh err_req only
  // matters when it coincides with a clear write (new error beats clear).
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      StNormal: begin
        if (err_req) begin
          state_d = StError;
          code_d  = err_code;
        end
      end
      StError: begin
        if (wr_clear) begin
          if (err_req) code_d = err_code;
          else         state_d = StNormal;
        end
      end
      default: state_d = StNormal;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    err_active = (state_q == StError);
    leds_d     = 8'h00;
    if (state_q == StError) begin
      leds_d = fast ? code_q : 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        unique case (mode_q[2*i +: 2])
          2'b00: leds_d[i] = 1'b0;
          2'b01: leds_d[i] = 1'b1;
          2'b10: leds_d[i] = slow;
          2'b11: leds_d[i] = fast;
          default: leds_d[i] = 1'b0;
        endcase
      end
`ifdef LED_CTRL_HEARTBEAT_EN
      leds_d[7] = slow;
`else
      leds_d[7] = leds_d[7];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 16'h0;
      code_q <= 8'h0;
      leds_q <= 8'h00;
    end else begin
      mode_q <= mode_d;
      code_q <= code_d;
      leds_q <= leds_d;
    end
  end

  assign leds = leds_q;

endmodule
